rr_req_arbiter16: RTL and testbench



---
 rtl/rr_req_arbiter16.sv | 81 ++++++++
 tb/tb_rr_req_arbiter16.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/rr_req_arbiter16.sv
// Round-robin request arbiter feeding the 16-to-4 encoder: sticky pending set,
// rotating-priority selection, registered one-hot grant with valid/ready handshake.
module rr_req_arbiter16 #(
  parameter int N  = 16,
  parameter int PW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [0:N-1]  req,
  input  logic          en,
  output logic [0:N-1]  gnt,
  output logic          gnt_valid,
  input  logic          gnt_ready,
  output logic [0:N-1]  pend,
  output logic          busy
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t          state;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   win;
  logic [0:N-1]    issue_mask;
  logic            any_pend;
  logic            xfer;
  logic            issue;

  // Rotating priority: search upward from last+1; PW-bit index arithmetic
  // provides the wrap past N-1 because N is exactly 2**PW.
  function automatic logic [PW-1:0] pick_winner(input logic [0:N-1] p,
                                                input logic [PW-1:0] last);
    logic [PW-1:0] idx;
    logic          found;
    pick_winner = last;
    found       = 1'b0;
    for (int k = 1; k <= N; k++) begin
      idx = last + k[PW-1:0];
      if (!found && p[idx]) begin
        pick_winner = idx;
        found       = 1'b1;
      end
    end
  endfunction

  function automatic logic [0:N-1] one_hot(input logic [PW-1:0] idx);
    one_hot      = '0;
    one_hot[idx] = 1'b1;
  endfunction

  assign gnt_valid = (state == HOLD);
  assign busy      = gnt_valid | (|pend);

  always_comb begin
    any_pend   = |pend;
    xfer       = gnt_valid & gnt_ready;
    issue      = en & any_pend & ((state == IDLE) | xfer);
    win        = pick_winner(pend, ptr);
    issue_mask = issue ? one_hot(win) : '0;
  end

  // A req landing on the bit being issued this cycle is kept for a later grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      gnt   <= '0;
      ptr   <= PW'(N - 1);
      pend  <= '0;
    end else begin
      pend <= (pend & ~issue_mask) | req;
      if (issue) begin
        state <= HOLD;
        gnt   <= issue_mask;
        ptr   <= win;
      end else if (xfer) begin
        state <= IDLE;
        gnt   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_rr_req_arbiter16.sv
// Directed bench for rr_req_arbiter16: reset, single grant, round-robin order,
// backpressure/merging, enable gating and saturation fairness.
module tb_rr_req_arbiter16;

  localparam int N = 16;

  logic          clk;
  logic          rst_n;
  logic [0:N-1]  req;
  logic          en;
  logic [0:N-1]  gnt;
  logic          gnt_valid;
  logic          gnt_ready;
  logic [0:N-1]  pend;
  logic          busy;

  int errors = 0;
  int checks = 0;

  rr_req_arbiter16 #(.N(16), .PW(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .en        (en),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_ready (gnt_ready),
    .pend      (pend),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [0:N-1] oh(input int i);
    logic [0:N-1] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic chk_v(input string tag, input logic [0:N-1] obs, input logic [0:N-1] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One rising edge, then return at the following falling edge for sampling/driving.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n     = 1'b0;
    req       = '0;
    en        = 1'b1;
    gnt_ready = 1'b0;

    // Reset held with random activity
    repeat (3) begin
      req       = N'($urandom);
      gnt_ready = 1'($urandom);
      step();
    end
    chk_v("rst_gnt", gnt, '0);
    chk_b("rst_valid", gnt_valid, 1'b0);
    chk_v("rst_pend", pend, '0);
    chk_b("rst_busy", busy, 1'b0);
    rst_n     = 1'b1;
    req       = '0;
    gnt_ready = 1'b1;
    step();

    // Single request on 5
    req = oh(5);
    step();
    req = '0;
    chk_v("single_pend", pend, oh(5));
    chk_b("single_novalid", gnt_valid, 1'b0);
    step();
    chk_v("single_gnt", gnt, oh(5));
    chk_b("single_valid", gnt_valid, 1'b1);
    chk_v("single_pend_clr", pend, '0);
    step();
    chk_b("single_valid_off", gnt_valid, 1'b0);
    chk_v("single_gnt_off", gnt, '0);
    chk_b("single_busy_off", busy, 1'b0);

    // Asynchronous reset while holding a grant
    gnt_ready = 1'b0;
    req = oh(8);
    step();
    req = '0;
    step();
    chk_v("hold_gnt8", gnt, oh(8));
    #2 rst_n = 1'b0;
    #1;
    chk_v("async_rst_gnt", gnt, '0);
    chk_b("async_rst_valid", gnt_valid, 1'b0);
    chk_v("async_rst_pend", pend, '0);
    chk_b("async_rst_busy", busy, 1'b0);
    rst_n     = 1'b1;
    gnt_ready = 1'b1;
    @(negedge clk);
    chk_b("post_rst_idle", gnt_valid, 1'b0);

    // Round-robin 0,3,15 with no bubble
    req = oh(0) | oh(3) | oh(15);
    step();
    req = '0;
    chk_v("rr_pend", pend, oh(0) | oh(3) | oh(15));
    step();
    chk_v("rr_gnt0", gnt, oh(0));
    step();
    chk_v("rr_gnt3", gnt, oh(3));
    chk_b("rr_valid3", gnt_valid, 1'b1);
    step();
    chk_v("rr_gnt15", gnt, oh(15));
    chk_b("rr_valid15", gnt_valid, 1'b1);
    step();
    chk_b("rr_done_valid", gnt_valid, 1'b0);
    chk_v("rr_done_gnt", gnt, '0);

    // Wrap: ptr at 15, so 0 wins before 15
    req = oh(15) | oh(0);
    step();
    req = '0;
    step();
    chk_v("wrap_gnt0", gnt, oh(0));
    step();
    chk_v("wrap_gnt15", gnt, oh(15));
    step();
    chk_b("wrap_done", gnt_valid, 1'b0);

    // Enable gating
    en  = 1'b0;
    req = oh(1) | oh(9);
    step();
    req = '0;
    step();
    step();
    chk_v("en_pend", pend, oh(1) | oh(9));
    chk_b("en_novalid", gnt_valid, 1'b0);
    chk_b("en_busy", busy, 1'b1);
    en = 1'b1;
    step();
    chk_v("en_gnt1", gnt, oh(1));
    step();
    chk_v("en_gnt9", gnt, oh(9));
    step();
    chk_b("en_done", gnt_valid, 1'b0);

    // Backpressure and merging
    gnt_ready = 1'b0;
    req = oh(2);
    step();
    req = '0;
    step();
    chk_v("bp_gnt2", gnt, oh(2));
    req = oh(2) | oh(7);
    for (int i = 0; i < 4; i++) begin
      step();
      chk_v("bp_hold_gnt", gnt, oh(2));
      chk_b("bp_hold_valid", gnt_valid, 1'b1);
    end
    req = '0;
    chk_v("bp_pend", pend, oh(2) | oh(7));
    gnt_ready = 1'b1;
    step();
    chk_v("bp_gnt7", gnt, oh(7));
    chk_v("bp_pend2", pend, oh(2));
    step();
    chk_v("bp_gnt2b", gnt, oh(2));
    step();
    chk_b("bp_done_valid", gnt_valid, 1'b0);
    chk_b("bp_done_busy", busy, 1'b0);

    // Saturation fairness from a fresh pointer
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    req = '1;
    step();
    chk_v("sat_pend", pend, '1);
    chk_b("sat_novalid", gnt_valid, 1'b0);
    for (int k = 0; k < 32; k++) begin
      step();
      chk_v("sat_gnt", gnt, oh(k % 16));
      chk_b("sat_valid", gnt_valid, 1'b1);
      chk_b("sat_onehot", $onehot(gnt), 1'b1);
    end
    chk_v("sat_pend_kept", pend, '1);
    req = '0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
